// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stage enables/flushes, operand forwarding, memory-wait timeout.
// Define PIPELINE_HAZARD_CTRL_FORWARDING_EN to build with EX-stage operand forwarding.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  mem_rd,
    input  logic        mem_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic        wb_reg_write,
    input  logic        ex_branch_taken,
    input  logic        mem_access,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        mem_timeout,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StError
    } state_e;

    localparam logic [7:0] WaitMax = 8'(MEM_WAIT_MAX);

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        data_hazard;
    logic [1:0]  fwd_a_raw;
    logic [1:0]  fwd_b_raw;
    logic        run_eq;

    // x0 is hardwired zero, so it never produces a dependency.
    function automatic logic reg_match(input logic [4:0] rd, input logic we,
                                       input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

    function automatic logic id_match(input logic [4:0] rd, input logic we,
                                      input logic [4:0] rs1, input logic use1,
                                      input logic [4:0] rs2, input logic use2);
        return (use1 && reg_match(rd, we, rs1)) || (use2 && reg_match(rd, we, rs2));
    endfunction

`ifdef PIPELINE_HAZARD_CTRL_FORWARDING_EN
    // Only a load still in EX cannot be forwarded in time.
    assign data_hazard = ex_mem_read &&
        id_match(ex_rd, ex_reg_write, id_rs1, id_uses_rs1, id_rs2, id_uses_rs2);

    always_comb begin
        fwd_a_raw = 2'b00;
        fwd_b_raw = 2'b00;
        if (reg_match(mem_rd, mem_reg_write, ex_rs1)) begin
            fwd_a_raw = 2'b10;
        end else if (reg_match(wb_rd, wb_reg_write, ex_rs1)) begin
            fwd_a_raw = 2'b01;
        end
        if (reg_match(mem_rd, mem_reg_write, ex_rs2)) begin
            fwd_b_raw = 2'b10;
        end else if (reg_match(wb_rd, wb_reg_write, ex_rs2)) begin
            fwd_b_raw = 2'b01;
        end
    end
`else
    // Write-through register file: WB results are visible in ID, so only EX and MEM matter.
    assign data_hazard =
        id_match(ex_rd, ex_reg_write, id_rs1, id_uses_rs1, id_rs2, id_uses_rs2) ||
        id_match(mem_rd, mem_reg_write, id_rs1, id_uses_rs1, id_rs2, id_uses_rs2);

    assign fwd_a_raw = 2'b00;
    assign fwd_b_raw = 2'b00;

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{ex_rs1, ex_rs2, wb_rd, wb_reg_write, ex_mem_read};
`endif

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        run_eq      = 1'b0;
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;

        unique case (state_q)
            StRun: begin
                if (mem_access && !mem_ready) begin
                    state_d    = StMemWait;
                    wait_cnt_d = 8'd1;
                end else begin
                    run_eq = 1'b1;
                end
            end
            StMemWait: begin
                if (mem_ready) begin
                    // Ready wins even on the final allowed wait cycle.
                    state_d    = StRun;
                    wait_cnt_d = 8'd0;
                    run_eq     = 1'b1;
                end else if (wait_cnt_q >= WaitMax) begin
                    state_d = StError;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = 8'd0;
            end
        endcase

        if (run_eq) begin
            if (ex_branch_taken) begin
                pc_en       = 1'b1;
                if_id_en    = 1'b1;
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en   = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (data_hazard) begin
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en   = 1'b1;
                id_ex_flush = 1'b1;
            end else begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
            end
        end

        if (rst) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_mem_en   = 1'b0;
            mem_wb_en   = 1'b0;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q != StError) && !pc_en && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            wait_cnt_q  <= 8'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_a       = rst ? 2'b00 : fwd_a_raw;
    assign fwd_b       = rst ? 2'b00 : fwd_b_raw;
    assign mem_timeout = (state_q == StError);
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed literal cases plus randomized
// traffic compared every cycle against a streak-counting behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int MAX = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_reg_write, ex_mem_read;
    logic        mem_reg_write, wb_reg_write, ex_branch_taken, mem_access, mem_ready;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, mem_timeout;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_count;

    int n_total = 0;
    int n_pass  = 0;

    pipeline_hazard_ctrl #(.MEM_WAIT_MAX(MAX)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .ex_branch_taken(ex_branch_taken),
        .mem_access(mem_access), .mem_ready(mem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_timeout(mem_timeout), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int m_streak = 0;   // consecutive not-ready cycles of the current memory access
    bit m_err    = 1'b0;
    int m_stall  = 0;

    function automatic bit writes_src(input logic [4:0] rd, input logic we);
        if (!we || rd == 0) return 1'b0;
        return (id_uses_rs1 && id_rs1 == rd) || (id_uses_rs2 && id_rs2 == rd);
    endfunction

    function automatic bit model_hazard();
`ifdef PIPELINE_HAZARD_CTRL_FORWARDING_EN
        return ex_mem_read && writes_src(ex_rd, ex_reg_write);
`else
        return writes_src(ex_rd, ex_reg_write) || writes_src(mem_rd, mem_reg_write);
`endif
    endfunction

    function automatic logic [1:0] model_fwd(input logic [4:0] rs);
`ifdef PIPELINE_HAZARD_CTRL_FORWARDING_EN
        if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b10;
        if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b01;
`endif
        return 2'b00;
    endfunction

    // exp bits: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
    always @(negedge clk) begin
        logic [6:0] e;
        logic [1:0] ea, eb;
        bit waiting;
        waiting = (m_streak > 0) ? !mem_ready : (mem_access && !mem_ready);
        if (rst || m_err || waiting) e = 7'b0;
        else if (ex_branch_taken)    e = 7'b11111_11;
        else if (model_hazard())     e = 7'b00111_01;
        else                         e = 7'b11111_00;
        ea = rst ? 2'b00 : model_fwd(ex_rs1);
        eb = rst ? 2'b00 : model_fwd(ex_rs2);

        check("enables", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, e[6:2]);
        check("flushes", {if_id_flush, id_ex_flush}, e[1:0]);
        check("fwd_a", fwd_a, ea);
        check("fwd_b", fwd_b, eb);
        check("stall_count", stall_count, m_stall);
        if (!rst) check("mem_timeout", mem_timeout, m_err);

        if (!m_err && !e[6] && m_stall < 65535) m_stall++;
        if (!m_err) begin
            if (m_streak > 0) begin
                if (mem_ready) m_streak = 0;
                else begin
                    m_streak++;
                    if (m_streak > MAX) m_err = 1'b1;
                end
            end else if (mem_access && !mem_ready) begin
                m_streak = 1;
            end
        end
        if (rst) begin
            m_streak = 0;
            m_err    = 1'b0;
            m_stall  = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_uses_rs1, id_uses_rs2, ex_reg_write, ex_mem_read} = '0;
        {mem_reg_write, wb_reg_write, ex_branch_taken, mem_access} = '0;
        mem_ready = 1'b1;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        idle();
        cyc();
        rst = 1'b0;
    endtask

    // Holds mem_ready low for n_low cycles, then raises it; returns cycles with all enables 0.
    task automatic mem_stall(input int n_low, output int zero_cycles);
        zero_cycles = 0;
        for (int i = 0; i < n_low; i++) begin
            cyc();
            mem_access = 1'b1;
            mem_ready  = 1'b0;
            @(negedge clk);
            if (!pc_en && !if_id_en && !id_ex_en && !ex_mem_en && !mem_wb_en) zero_cycles++;
        end
        cyc();
        mem_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int zc;
        int bias;
        rst = 1'b1;
        idle();
        cyc();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("reset_stall_count", stall_count, 0);
        check("reset_pc_en", pc_en, 1);
        check("reset_timeout", mem_timeout, 0);

`ifdef PIPELINE_HAZARD_CTRL_FORWARDING_EN
        cyc();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        @(negedge clk);
        check("load_use_pc_en", pc_en, 0);
        check("load_use_flush", id_ex_flush, 1);
        cyc();
        idle();
        @(negedge clk);
        check("load_use_resume", pc_en, 1);
        check("load_use_stalls", stall_count, 1);
        cyc();
        mem_rd = 5'd7; mem_reg_write = 1'b1; wb_rd = 5'd7; wb_reg_write = 1'b1; ex_rs1 = 5'd7;
        @(negedge clk);
        check("fwd_exmem", fwd_a, 2'b10);
        cyc();
        mem_rd = 5'd0;
        @(negedge clk);
        check("fwd_memwb", fwd_a, 2'b01);
        cyc();
        wb_rd = 5'd0; ex_rs1 = 5'd0;
        @(negedge clk);
        check("fwd_x0", fwd_a, 2'b00);
`else
        cyc();
        ex_rd = 5'd3; ex_reg_write = 1'b1; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
        @(negedge clk);
        check("raw_ex_pc_en", pc_en, 0);
        check("raw_ex_flush", id_ex_flush, 1);
        cyc();
        ex_rd = 5'd0; ex_reg_write = 1'b0; mem_rd = 5'd3; mem_reg_write = 1'b1;
        @(negedge clk);
        check("raw_mem_pc_en", pc_en, 0);
        cyc();
        idle();
        @(negedge clk);
        check("raw_resume", pc_en, 1);
        check("raw_stalls", stall_count, 2);
`endif

        // Branch overrides a load-use hazard.
        do_reset();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd9;
        id_rs2 = 5'd9; id_uses_rs2 = 1'b1; ex_branch_taken = 1'b1;
        @(negedge clk);
        check("branch_pc_en", pc_en, 1);
        check("branch_flushes", {if_id_flush, id_ex_flush}, 2'b11);
        cyc();
        idle();
        @(negedge clk);
        check("branch_no_stall", stall_count, 0);

        // Four-cycle memory wait.
        do_reset();
        mem_stall(4, zc);
        @(negedge clk);
        check("wait4_zero_cycles", zc, 4);
        check("wait4_resume", pc_en, 1);
        cyc();
        idle();
        @(negedge clk);
        check("wait4_stalls", stall_count, 4);

        // Ready arrives exactly when the counter reaches the limit.
        do_reset();
        mem_stall(MAX, zc);
        @(negedge clk);
        check("edge_resume", pc_en, 1);
        check("edge_no_timeout", mem_timeout, 0);

        // One more low cycle times out, sticky until reset.
        do_reset();
        mem_stall(MAX + 1, zc);
        @(negedge clk);
        check("timeout_set", mem_timeout, 1);
        check("timeout_pc_en", pc_en, 0);
        repeat (3) cyc();
        idle();
        @(negedge clk);
        check("timeout_sticky", mem_timeout, 1);
        check("timeout_stall_frozen", stall_count, MAX + 1);
        do_reset();
        @(negedge clk);
        check("timeout_cleared", mem_timeout, 0);

        // Reset in the middle of a wait.
        cyc();
        mem_access = 1'b1; mem_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        @(negedge clk);
        check("rst_enables", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 0);
        cyc();
        rst = 1'b0;
        idle();
        @(negedge clk);
        check("rst_wait_stall", stall_count, 0);
        check("rst_wait_run", pc_en, 1);

        // Randomized traffic; the readiness bias changes in phases to reach timeouts.
        bias = 9;
        for (int i = 0; i < 4000; i++) begin
            cyc();
            if (i % 64 == 0) bias = (i % 192 == 0) ? 0 : ((i % 128 == 0) ? 5 : 9);
            rst             = ($urandom_range(0, 149) == 0);
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            ex_rs1          = 5'($urandom_range(0, 3));
            ex_rs2          = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            mem_rd          = 5'($urandom_range(0, 3));
            wb_rd           = 5'($urandom_range(0, 3));
            id_uses_rs1     = 1'($urandom_range(0, 1));
            id_uses_rs2     = 1'($urandom_range(0, 1));
            ex_reg_write    = 1'($urandom_range(0, 1));
            ex_mem_read     = 1'($urandom_range(0, 1));
            mem_reg_write   = 1'($urandom_range(0, 1));
            wb_reg_write    = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            mem_access      = ($urandom_range(0, 2) == 0);
            mem_ready       = ($urandom_range(0, 9) < bias);
        end
        cyc();
        rst = 1'b0;
        idle();
        @(negedge clk);
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MEM_WAIT_MAX, default 15: maximum consecutive data-memory wait cycles before timeout (range 1..255).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-005 id_uses_rs1, id_uses_rs2  input  1 each  the ID instruction reads rs1 / rs2.
REQ-006 ex_rs1, ex_rs2  input  5 each  source registers of the instruction in EX.
REQ-007 ex_rd, ex_reg_write, ex_mem_read  input  5/1/1  destination of the EX instruction; it writes a register; it is a load.
REQ-008 mem_rd, mem_reg_write  input  5/1  destination held in the EX/MEM register.
REQ-009 wb_rd, wb_reg_write  input  5/1  destination held in the MEM/WB register.
REQ-010 ex_branch_taken  input  1  branch or jump resolved taken in EX.
REQ-011 mem_access, mem_ready  input  1/1  MEM stage performs a load/store; data memory has completed it.
REQ-012 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  per-stage load enables.
REQ-013 if_id_flush, id_ex_flush  output  1 each  insert a bubble at the next edge (NOP, all write controls 0).
REQ-014 fwd_a, fwd_b  output  2 each  EX operand source: 00 register file, 10 EX/MEM, 01 MEM/WB.
REQ-015 mem_timeout  output  1  sticky memory-timeout error flag.
REQ-016 stall_count  output  16  saturating count of stalled cycles.

Function
REQ-017 Register 0 SHALL never cause a hazard or forward; a match SHALL require rd != 0 and the corresponding reg_write = 1.
REQ-018 The FSM SHALL have states RUN, MEM_WAIT and ERROR; all enable and flush outputs SHALL be combinational from the state and the inputs.
REQ-019 RUN with mem_access=1 and mem_ready=0: all enables SHALL be 0, and the FSM SHALL go to MEM_WAIT at the next edge with the wait counter set to 1.
REQ-020 MEM_WAIT: all enables SHALL stay 0 and flushes SHALL stay 0.
REQ-021 MEM_WAIT, mem_ready=1: the FSM SHALL return to RUN, and the RUN equations SHALL apply in that same cycle.
REQ-022 MEM_WAIT, mem_ready=0 with counter == MEM_WAIT_MAX: the FSM SHALL go to ERROR; otherwise the counter SHALL increment.
REQ-023 mem_ready=1 in the cycle the counter reaches MEM_WAIT_MAX: ready SHALL win and no timeout SHALL occur.
REQ-024 ERROR: all enables SHALL be 0, mem_timeout SHALL be 1, and the FSM SHALL hold until rst.
REQ-025 RUN, ex_branch_taken=1: all enables SHALL be 1 and if_id_flush = id_ex_flush = 1; this SHALL override any data-hazard stall in the same cycle.
REQ-026 RUN, data hazard and no branch: pc_en = if_id_en = 0, id_ex_flush = 1, and id_ex_en, ex_mem_en, mem_wb_en = 1.
REQ-027 RUN with no condition active: all enables SHALL be 1 and all flushes SHALL be 0.
REQ-028 A branch held in EX during MEM_WAIT SHALL be flushed on the RUN cycle in which the wait exits.
REQ-029 stall_count SHALL increment on every cycle with pc_en=0 in RUN or MEM_WAIT, SHALL saturate at 0xFFFF, and SHALL not count in ERROR.
REQ-030 The priority order SHALL be: rst > ERROR > memory wait > branch flush > data-hazard stall.

Reset
REQ-031 rst=1 at a rising edge SHALL set: state RUN, wait counter 0, stall_count 0, mem_timeout 0; this SHALL apply in any state, including mid-wait and ERROR.
REQ-032 While rst=1, all enables SHALL be 0, all flushes 0, and fwd_a = fwd_b = 00.

Configuration
REQ-033 The macro PIPELINE_HAZARD_CTRL_FORWARDING_EN SHALL select the data-hazard and forwarding behaviour.
REQ-034 With PIPELINE_HAZARD_CTRL_FORWARDING_EN defined, the data-hazard and forwarding rules SHALL be:
- A data hazard SHALL be only ex_mem_read=1 with ex_rd matching a used ID source.
- fwd_x = 10 SHALL be selected if mem_rd matches ex_rsx, else 01 if wb_rd matches, else 00.
- An EX/MEM match SHALL take priority over a MEM/WB match.
REQ-035 With the macro undefined, the data-hazard and forwarding rules SHALL be:
- A data hazard SHALL be ex_rd or mem_rd matching a used ID source (write-through register file, so no wb_rd check).
- fwd_a and fwd_b SHALL be constant 00.

Verification
REQ-036 With forwarding: load x5 in EX (ex_mem_read=1, ex_rd=5), ID add uses x5 -> one cycle with pc_en=0, id_ex_flush=1, stall_count=1; next cycle no stall.
REQ-037 With forwarding: mem_rd=wb_rd=7, ex_rs1=7 -> fwd_a=10; mem_rd=0, wb_rd=7 -> fwd_a=01; rd=0 with rs1=0 -> fwd_a=00.
REQ-038 Without forwarding: ALU writer ex_rd=3, ID uses x3 -> 2 stall cycles (matches on ex_rd, then mem_rd); stall_count=2.
REQ-039 Load with mem_ready low 4 cycles -> all enables 0 for 4 cycles, resume on the ready cycle; low 15 cycles with ready on the 15th -> no timeout; low 16 cycles -> mem_timeout=1, sticky until rst.
REQ-040 ex_branch_taken=1 together with a load-use hazard -> both flushes 1, pc_en=1, stall_count unchanged; rst asserted in MEM_WAIT -> RUN, counters 0 after the edge.
